// File: rtl/dmem_pkg.sv
// Shared widths, FSM encoding and port identifiers for the data-memory arbiter.
// Both the arbiter and its round-robin picker import this package.
package dmem_pkg;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 64;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_e;

  typedef logic port_t;

  localparam port_t PORT_A = 1'b0;
  localparam port_t PORT_B = 1'b1;

endpackage

// File: rtl/dmem_rr_pick.sv
// Two-way round-robin select: a lone requester wins outright.
// On a tie, the port that was not granted last time wins.
module dmem_rr_pick
  import dmem_pkg::*;
(
  input  logic [1:0] req,
  input  port_t      last_gnt,
  output logic       gnt_valid,
  output port_t      gnt_port
);

  always_comb begin
    gnt_valid = |req;
    if (&req) begin
      gnt_port = ~last_gnt;
    end else begin
      gnt_port = req[1] ? PORT_B : PORT_A;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter/sequencer in front of a single-port registered-read data memory.
// Port A is the CPU load/store stage, port B the debug/loader port.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DW    = dmem_pkg::DW,
  parameter int AW    = dmem_pkg::AW,
  parameter int DEPTH = dmem_pkg::DEPTH
) (
  input  logic          clock,
  input  logic          reset_n,

  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  output logic          a_err,

  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
  output logic          b_err,

  output logic [AW-1:0] mem_address,
  output logic          mem_write,
  output logic          mem_read,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,

  output logic          busy
);

  localparam logic [AW-1:0] DEPTH_LIM = AW'(DEPTH);

  state_e        state_q, state_d;
  port_t         last_gnt_q, last_gnt_d;
  port_t         owner_q, owner_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic [DW-1:0] a_rdata_q, a_rdata_d;
  logic [DW-1:0] b_rdata_q, b_rdata_d;

  logic          pick_valid;
  port_t         pick_port;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  dmem_rr_pick u_pick (
    .req       ({b_req, a_req}),
    .last_gnt  (last_gnt_q),
    .gnt_valid (pick_valid),
    .gnt_port  (pick_port)
  );

  assign sel_we    = (pick_port == PORT_B) ? b_we    : a_we;
  assign sel_addr  = (pick_port == PORT_B) ? b_addr  : a_addr;
  assign sel_wdata = (pick_port == PORT_B) ? b_wdata : a_wdata;

  // NOTE: every output and *_d gets a default before any branch, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    last_gnt_d  = last_gnt_q;
    owner_d     = owner_q;
    rd_addr_d   = rd_addr_q;
    a_rdata_d   = a_rdata_q;
    b_rdata_d   = b_rdata_q;
    mem_read    = 1'b1;
    mem_write   = 1'b0;
    mem_address = '0;
    mem_wdata   = '0;
    a_gnt       = 1'b0;
    b_gnt       = 1'b0;
    a_err       = 1'b0;
    b_err       = 1'b0;
    a_rvalid    = 1'b0;
    b_rvalid    = 1'b0;

    // While reset is asserted the defaults hold: dummy read of word 0, no strobes.
    if (reset_n) begin
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            last_gnt_d = pick_port;
            if (pick_port == PORT_A) a_gnt = 1'b1;
            else                     b_gnt = 1'b1;

            if (sel_addr >= DEPTH_LIM) begin
              if (pick_port == PORT_A) a_err = 1'b1;
              else                     b_err = 1'b1;
            end else if (sel_we) begin
              mem_write   = 1'b1;
              mem_read    = 1'b0;
              mem_address = sel_addr;
              mem_wdata   = sel_wdata;
            end else begin
              mem_address = sel_addr;
              rd_addr_d   = sel_addr;
              owner_d     = pick_port;
              state_d     = RD_WAIT;
            end
          end
        end

        RD_WAIT: begin
          // Keep the read address stable so the word under the strobe is not disturbed.
          mem_address = rd_addr_q;
          if (owner_q == PORT_A) begin
            a_rvalid  = 1'b1;
            a_rdata_d = mem_rdata;
          end else begin
            b_rvalid  = 1'b1;
            b_rdata_d = mem_rdata;
          end
          state_d = IDLE;
        end
      endcase
    end
  end

  // NOTE: sequential state is updated only with non-blocking assignments to avoid race ordering.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      last_gnt_q <= PORT_B;
      owner_q    <= PORT_A;
      rd_addr_q  <= '0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      owner_q    <= owner_d;
      rd_addr_q  <= rd_addr_d;
      a_rdata_q  <= a_rdata_d;
      b_rdata_q  <= b_rdata_d;
    end
  end

  // Read data is forwarded in the rvalid cycle and held afterwards.
  assign a_rdata = a_rvalid ? mem_rdata : a_rdata_q;
  assign b_rdata = b_rvalid ? mem_rdata : b_rdata_q;
  assign busy    = (state_q == RD_WAIT);

endmodule
